// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone SRAM slave.
package wb_sram_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned CNTW  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_sram_bank.sv
// DEPTH x 32 word store: one byte-enabled write port, one registered read port.
module wb_sram_bank
  import wb_sram_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic                 clr_i,
  input  logic [IDXW-1:0]      idx_i,
  input  logic [LANES-1:0]     be_i,
  input  logic [LANES*8-1:0]   wdata_i,
  output logic [LANES*8-1:0]   rdata_o
);

  logic [LANES*8-1:0] mem_q [DEPTH];
  logic [LANES*8-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (be_i[l]) mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic SRAM slave with programmable wait states.
// Define WB_SRAM_ERR_EN to terminate out-of-range accesses with wb_err_o.
module wb_sram_slave
  import wb_sram_pkg::*;
#(
  parameter int unsigned AWIDTH      = 8,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [AWIDTH-1:0] wb_adr_i,
  input  logic [LANES-1:0]  wb_sel_i,
  input  logic [DWIDTH-1:0] wb_dat_i,
  output logic [DWIDTH-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o
);

  localparam int unsigned IDXW = $clog2(DEPTH);

  wb_state_e         state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [IDXW-1:0]   idx_q;
  logic              we_q;
  logic [LANES-1:0]  sel_q;
  logic [DWIDTH-1:0] dat_q;
  logic              oob_q;
  logic              ack_q;
  logic              err_q;

  logic              req, in_idle, oob_in, go_done;
  logic              eff_we, eff_oob;
  logic [IDXW-1:0]   eff_idx;
  logic [LANES-1:0]  eff_sel;
  logic [DWIDTH-1:0] eff_dat;
  logic              unused_adr;

  assign req     = wb_cyc_i & wb_stb_i;
  assign in_idle = (state_q == StIdle);

`ifdef WB_SRAM_ERR_EN
  localparam logic [AWIDTH:0] RangeEnd = (AWIDTH+1)'(DEPTH * 4);
  assign oob_in = ({1'b0, wb_adr_i} >= RangeEnd);
`else
  assign oob_in = 1'b0;
`endif

  // Zero-wait transfers complete on the sampling edge, so bypass the latches in IDLE.
  assign eff_idx = in_idle ? wb_adr_i[IDXW+1:2] : idx_q;
  assign eff_we  = in_idle ? wb_we_i  : we_q;
  assign eff_sel = in_idle ? wb_sel_i : sel_q;
  assign eff_dat = in_idle ? wb_dat_i : dat_q;
  assign eff_oob = in_idle ? oob_in   : oob_q;

  assign go_done = ~wb_rst_i & req &
                   ((in_idle && WAIT_STATES == 0) || (state_q == StWait && cnt_q == '0));

  assign unused_adr = ^wb_adr_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      oob_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= go_done & ~eff_oob;
      err_q <= go_done & eff_oob;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q <= wb_adr_i[IDXW+1:2];
            we_q  <= wb_we_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_dat_i;
            oob_q <= oob_in;
            if (WAIT_STATES == 0) begin
              state_q <= StDone;
            end else begin
              state_q <= StWait;
              cnt_q   <= CNTW'(WAIT_STATES - 1);
            end
          end
        end
        StWait: begin
          if (!req) begin
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  wb_sram_bank #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_bank (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .we_i    (go_done & eff_we & ~eff_oob),
    .re_i    (go_done & ~eff_we & ~eff_oob),
    .clr_i   (go_done & eff_oob),
    .idx_i   (eff_idx),
    .be_i    (eff_sel),
    .wdata_i (eff_dat),
    .rdata_o (wb_dat_o)
  );

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule
